// File: rtl/btn_conditioner_pkg.sv
// btn_pkg: shared state type, default timing constants and sizing helper
// for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;
    localparam int REPEAT_DELAY_500MS  = 25_000_000;
    localparam int REPEAT_PERIOD_200MS = 10_000_000;

    // Counter width able to hold value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus between the raw pins (master side) and the conditioner (slave side).
interface btn_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;

    modport master (output btn_raw, input btn_level, input btn_pulse);
    modport slave  (input btn_raw, output btn_level, output btn_pulse);
endinterface

// File: rtl/btn_conditioner_channel.sv
// btn_channel: synchroniser, debounce FSM and press strobe for one button.
// Hold-to-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_200MS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int            CW       = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          RAW_IDLE = (ACTIVE_LOW != 0);

    logic          r_sync1;
    logic          r_sync2;
    btn_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_pulse;

    logic          w_s;
    btn_state_t    w_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_press_edge;
    logic          w_rep_fire;

    // Sync flops reset to the idle pin level so a held button is seen as a new press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= RAW_IDLE;
            r_sync2 <= RAW_IDLE;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2 ^ RAW_IDLE;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            RELEASED: begin
                if (w_s) begin
                    w_next     = PRESS_WAIT;
                    w_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s)                  w_next = RELEASED;
                else if (r_cnt == CNT_LAST) w_next = PRESSED;
                else                       w_cnt_next = r_cnt + CW'(1);
            end
            PRESSED: begin
                if (!w_s) begin
                    w_next     = RELEASE_WAIT;
                    w_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_s)                   w_next = PRESSED;
                else if (r_cnt == CNT_LAST) w_next = RELEASED;
                else                       w_cnt_next = r_cnt + CW'(1);
            end
            default: w_next = RELEASED;
        endcase
    end

    assign w_press_edge = (r_state == PRESS_WAIT) && (w_next == PRESSED);

`ifdef BTN_AUTOREPEAT_EN
    localparam int            RW = clog2_min1((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_first;
    logic          w_rep_held;

    // Counts only while steadily held; frozen across a release bounce.
    assign w_rep_held = (r_state == PRESSED) && w_s;
    assign w_rep_fire = w_rep_held &&
                        (r_rep_cnt == (r_rep_first ? REP_FIRST_LAST : REP_NEXT_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_press_edge || (w_next == RELEASED)) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_held) begin
            if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
            end
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_level <= (w_next == PRESSED) || (w_next == RELEASE_WAIT);
            r_pulse <= w_press_edge || w_rep_fire;
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent debounced buttons with one-cycle press pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_200MS
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus
);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_pulse;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (bus.btn_raw[g]),
            .o_level (w_level[g]),
            .o_pulse (w_pulse[g])
        );
    end

    assign bus.btn_level = w_level;
    assign bus.btn_pulse = w_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed latency/bounce/reset scenarios plus random
// bounce traffic compared against a run-length reference model.
module tb_btn_conditioner;

    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    btn_conditioner_if #(.N_BTN(N)) bus ();

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: the pressed level seen by the debouncer lags the pin by two edges;
    // the accepted level flips once DEB+1 consecutive samples disagree with it.
    logic [N-1:0] m_h1, m_h2, m_level, m_pulse;
    int           m_run   [N];
    int           m_rep   [N];
    bit           m_first [N];
    bit           m_obs, m_held;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_h1    = '0;
            m_h2    = '0;
            m_level = '0;
            m_pulse = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i]   = 0;
                m_rep[i]   = 0;
                m_first[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_obs      = m_h2[i];
                m_held     = m_level[i] && (m_run[i] == 0);
                m_pulse[i] = 1'b0;
                m_run[i]   = (m_obs != m_level[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DEB + 1) begin
                    m_level[i] = m_obs;
                    m_pulse[i] = m_obs;
                    m_run[i]   = 0;
                    m_rep[i]   = 0;
                    m_first[i] = 1'b1;
                end else if (AUTOREP && m_held && m_obs) begin
                    m_rep[i]++;
                    if (m_rep[i] == (m_first[i] ? RD : RP)) begin
                        m_pulse[i] = 1'b1;
                        m_rep[i]   = 0;
                        m_first[i] = 1'b0;
                    end
                end
            end
            m_h2 = m_h1;
            m_h1 = ~bus.btn_raw;
        end
    end

    task automatic test_reset();
        bus.btn_raw = '1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.btn_level !== 3'b000) begin
            errors++; $display("FAIL reset_level got=%b exp=000", bus.btn_level);
        end
        checks++;
        if (bus.btn_pulse !== 3'b000) begin
            errors++; $display("FAIL reset_pulse got=%b exp=000", bus.btn_pulse);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== 6'b0) begin
                errors++; $display("FAIL reset_idle i=%0d level=%b pulse=%b exp 000", i, bus.btn_level, bus.btn_pulse);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [N-1:0] el, ep;
        bus.btn_raw[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            el = (i >= 7) ? 3'b001 : 3'b000;
            ep = (i == 7) ? 3'b001 : 3'b000;
            checks++;
            if (bus.btn_level !== el) begin
                errors++; $display("FAIL clean_press_level i=%0d got=%b exp=%b", i, bus.btn_level, el);
            end
            checks++;
            if (bus.btn_pulse !== ep) begin
                errors++; $display("FAIL clean_press_pulse i=%0d got=%b exp=%b", i, bus.btn_pulse, ep);
            end
        end
        bus.btn_raw[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            el = (i >= 7) ? 3'b000 : 3'b001;
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== {el, 3'b000}) begin
                errors++; $display("FAIL clean_release i=%0d level=%b pulse=%b exp level=%b pulse=000", i, bus.btn_level, bus.btn_pulse, el);
            end
        end
    endtask

    task automatic test_press_bounce();
        logic [N-1:0] el, ep;
        bus.btn_raw[2] = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            el = (i >= 11) ? 3'b100 : 3'b000;
            ep = (i == 11) ? 3'b100 : 3'b000;
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== {el, ep}) begin
                errors++; $display("FAIL press_bounce i=%0d level=%b pulse=%b exp level=%b pulse=%b", i, bus.btn_level, bus.btn_pulse, el, ep);
            end
            if (i == 3) bus.btn_raw[2] = 1'b1;
            if (i == 4) bus.btn_raw[2] = 1'b0;
        end
        bus.btn_raw[2] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            el = (i >= 7) ? 3'b000 : 3'b100;
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== {el, 3'b000}) begin
                errors++; $display("FAIL press_bounce_release i=%0d level=%b pulse=%b exp level=%b", i, bus.btn_level, bus.btn_pulse, el);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [N-1:0] el, ep;
        bus.btn_raw[1] = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            el = (i >= 7 && i < 21) ? 3'b010 : 3'b000;
            ep = (i == 7) ? 3'b010 : 3'b000;
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== {el, ep}) begin
                errors++; $display("FAIL release_bounce i=%0d level=%b pulse=%b exp level=%b pulse=%b", i, bus.btn_level, bus.btn_pulse, el, ep);
            end
            if (i == 8)  bus.btn_raw[1] = 1'b1;
            if (i == 10) bus.btn_raw[1] = 1'b0;
            if (i == 14) bus.btn_raw[1] = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] el, ep;
        bus.btn_raw[1] = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (bus.btn_level !== 3'b010) begin
            errors++; $display("FAIL reset_mid_pre level got=%b exp=010", bus.btn_level);
        end
        bus.btn_raw[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.btn_level, bus.btn_pulse} !== 6'b0) begin
            errors++; $display("FAIL reset_mid_async level=%b pulse=%b exp 000", bus.btn_level, bus.btn_pulse);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            el = (i >= 7) ? 3'b011 : 3'b000;
            ep = (i == 7) ? 3'b011 : 3'b000;
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== {el, ep}) begin
                errors++; $display("FAIL reset_mid_repress i=%0d level=%b pulse=%b exp level=%b pulse=%b", i, bus.btn_level, bus.btn_pulse, el, ep);
            end
        end
        bus.btn_raw = '1;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.btn_level !== 3'b000) begin
            errors++; $display("FAIL reset_mid_release level got=%b exp=000", bus.btn_level);
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] el, ep;
        bus.btn_raw = '0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            el = (i >= 7) ? 3'b111 : 3'b000;
            ep = (i == 7) ? 3'b111 : 3'b000;
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== {el, ep}) begin
                errors++; $display("FAIL simultaneous i=%0d level=%b pulse=%b exp level=%b pulse=%b", i, bus.btn_level, bus.btn_pulse, el, ep);
            end
        end
        bus.btn_raw = '1;
        repeat (8) @(negedge clk);
        checks++;
        if ({bus.btn_level, bus.btn_pulse} !== 6'b0) begin
            errors++; $display("FAIL simultaneous_release level=%b pulse=%b exp 000", bus.btn_level, bus.btn_pulse);
        end
    endtask

    task automatic test_autorepeat();
        logic [N-1:0] el, ep;
        bit           rep;
        bus.btn_raw[1] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            rep = AUTOREP && (i == 17 || i == 22 || i == 27 || i == 32);
            el  = (i >= 7 && i < 39) ? 3'b010 : 3'b000;
            ep  = (i == 7 || rep) ? 3'b010 : 3'b000;
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== {el, ep}) begin
                errors++; $display("FAIL autorepeat i=%0d level=%b pulse=%b exp level=%b pulse=%b", i, bus.btn_level, bus.btn_pulse, el, ep);
            end
            if (i == 32) bus.btn_raw[1] = 1'b1;
        end
    endtask

    task automatic test_random();
        int remain [N];
        for (int ch = 0; ch < N; ch++) remain[ch] = $urandom_range(1, 8);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (bus.btn_level !== m_level) begin
                errors++; $display("FAIL random_level cycle=%0d got=%b exp=%b", c, bus.btn_level, m_level);
            end
            checks++;
            if (bus.btn_pulse !== m_pulse) begin
                errors++; $display("FAIL random_pulse cycle=%0d got=%b exp=%b", c, bus.btn_pulse, m_pulse);
            end
            for (int ch = 0; ch < N; ch++) begin
                remain[ch]--;
                if (remain[ch] == 0) begin
                    bus.btn_raw[ch] = ~bus.btn_raw[ch];
                    remain[ch] = $urandom_range(1, 2 * DEB + 2);
                end
            end
        end
        bus.btn_raw = '1;
        for (int c = 0; c < 2 * DEB + 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.btn_level, bus.btn_pulse} !== {m_level, m_pulse}) begin
                errors++; $display("FAIL random_settle cycle=%0d level=%b pulse=%b exp level=%b pulse=%b", c, bus.btn_level, bus.btn_pulse, m_level, m_pulse);
            end
        end
        checks++;
        if (bus.btn_level !== 3'b000) begin
            errors++; $display("FAIL random_final level got=%b exp=000", bus.btn_level);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_reset_mid();
        test_simultaneous();
        test_autorepeat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Per-button input conditioner in front of the clock modifier and mode logic: two-flop synchronises raw push-buttons, debounces them, and emits one-cycle press pulses. It replaces direct use of raw `up_btn`/`st_btn`/`mode_btn` levels, so each physical press advances state exactly once. An optional hold-to-repeat feature generates repeated pulses for fast time setting.

## Interface
- `N_BTN`, 3: number of independent button channels.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a new level must persist before it is accepted; 20 ms at 50 MHz. Must be ≥ 2.
- `ACTIVE_LOW`, 1: 1 means a raw input of 0 is a press (board KEYs); 0 means a raw input of 1 is a press.
- `REPEAT_DELAY`, 25_000_000: cycles held in PRESSED before the first repeat pulse. Used only with the repeat feature.
- `REPEAT_PERIOD`, 10_000_000: cycles between later repeat pulses. Used only with the repeat feature.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous and active-low. The clock is the only clock in the block.
- `btn_raw`  in  N_BTN  asynchronous raw button pins.
- `btn_level`  out  N_BTN  debounced pressed level; 1 means pressed.
- `btn_pulse`  out  N_BTN  one-cycle press strobe per channel.

## Operation
- All channels are identical and fully independent.
- Synchroniser: `sync1` then `sync2` registers. `s` is `sync2` after the polarity normalisation (pressed = 1). On reset, both sync flops load the raw inactive level, so `s` = 0.
- Per-channel state machine with counter `cnt`. `cnt` width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1. The transitions are:
  - RELEASED: if `s`=1, go to PRESS_WAIT with `cnt`=0.
  - PRESS_WAIT: if `s`=0, go to RELEASED. Otherwise, if `cnt`=DEBOUNCE_CYCLES−1, go to PRESSED and set `btn_pulse`. Otherwise `cnt`++.
  - PRESSED: if `s`=0, go to RELEASE_WAIT with `cnt`=0.
  - RELEASE_WAIT: if `s`=1, go back to PRESSED with no pulse (release bounce). Otherwise, if `cnt`=DEBOUNCE_CYCLES−1, go to RELEASED. Otherwise `cnt`++.
- `btn_level` = 1 in PRESSED or RELEASE_WAIT. It is registered and decoded from state flops, so it is glitch-free.
- `btn_pulse` is registered. It is high for exactly one cycle: the cycle in which the state first reads PRESSED after PRESS_WAIT.
- A release never generates a pulse.
- A bounce shorter than DEBOUNCE_CYCLES in either direction produces no output change.
- Counters never wrap. `cnt` saturates logically because the state always leaves its WAIT state at DEBOUNCE_CYCLES−1.

## Timing
- Reset values: `btn_level`=0, `btn_pulse`=0, state=RELEASED, `cnt`=0, sync flops at the inactive raw level.
- Press latency, raw input clean and first sampled at edge E0:
  - `sync1` at E0.
  - `s`=1 at E1.
  - PRESS_WAIT at E2.
  - `btn_level` and `btn_pulse` rise at E(DEBOUNCE_CYCLES+2).
- Release latency is the same: `btn_level` falls at E(DEBOUNCE_CYCLES+2) after the release is first sampled.
- Reset asserted mid-operation: all flops clear asynchronously. A pending pulse is dropped.
- A button still held when reset releases is treated as a new press. A pulse follows after the full press latency.
- Simultaneous presses on different channels produce pulses in the same cycle. There is no arbitration.

## Configuration
- Macro: `BTN_AUTOREPEAT_EN`.
- Defined:
  - A per-channel repeat counter is cleared on the PRESS_WAIT→PRESSED transition.
  - It counts in PRESSED and freezes in RELEASE_WAIT.
  - It emits a `btn_pulse` REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles while held.
  - It is cleared on entering RELEASED.
- Undefined: no repeat counter is built, the REPEAT_* parameters are ignored, and there is exactly one pulse per press.

## Structure
- Package `btn_pkg`:
  - `btn_state_t` enum: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - Constants `DEBOUNCE_20MS_50MHZ` = 1_000_000, `REPEAT_DELAY_500MS` = 25_000_000, `REPEAT_PERIOD_200MS` = 10_000_000.
- Sub-module `btn_channel`: the synchroniser, state machine, counter and optional repeat logic for one button.
- The top instantiates `N_BTN` copies of `btn_channel` in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=1 unless stated.
- **Clean press:** `btn_raw[0]` 1→0 and held, first sampled at E0.
  - `btn_level[0]` rises at E6.
  - `btn_pulse[0]` is high in the E6 cycle only.
  - Other channels stay 0.
- **Press bounce:** raw low for 3 cycles, high for 1, then low and held. No output until 4 consecutive stable cycles have been counted after the last bounce, then a single pulse.
- **Release bounce:** while pressed, raw high for 2 cycles, then low again.
  - `btn_level` stays 1.
  - No second pulse.
  - A later clean release drops `btn_level` 6 edges after it is sampled.
- **Reset mid-operation:** pull `rst` low while in PRESS_WAIT, with the button held.
  - Outputs are 0 immediately.
  - After `rst` rises, a pulse appears 6 edges after the first sampling edge.
- **Simultaneous press:** all 3 channels pressed in the same cycle. All three pulses coincide in one cycle.
- **`BTN_AUTOREPEAT_EN` defined, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5, held 30 cycles:**
  - Pulses occur at press, then +10, +15, +20, +25 cycles.
  - With the macro undefined, only the press pulse occurs.
